// File: rtl/quadgen_pkg.sv
// Shared definitions for the quadrature generator.
//   state_t         : controller state (IDLE / RUN)
//   PH_0..PH_3      : quadrature phase sequence {B,A} in forward (up) order
//   DWELL_DEFAULT   : default number of ce ticks spent in each phase
//   phase_next()    : next phase for one step up or down
package quadgen_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Forward order is 00 -> 01 -> 11 -> 10 -> 00; reverse order counts down.
  localparam logic [1:0] PH_0 = 2'b00;
  localparam logic [1:0] PH_1 = 2'b01;
  localparam logic [1:0] PH_2 = 2'b11;
  localparam logic [1:0] PH_3 = 2'b10;

  localparam int DWELL_DEFAULT = 4;
  localparam int CNT_W         = 8;   // holds DWELL-1 for DWELL up to 255
  localparam int STEP_W        = 16;

  function automatic logic [1:0] phase_next(input logic [1:0] ph, input logic up);
    logic [1:0] nxt;
    case (ph)
      PH_0:    nxt = up ? PH_1 : PH_3;
      PH_1:    nxt = up ? PH_2 : PH_0;
      PH_2:    nxt = up ? PH_3 : PH_1;
      default: nxt = up ? PH_0 : PH_2;   // PH_3
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quadgen_quadstep.sv
// Two-bit Gray-coded phase register.
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset, phase returns to 00
//   step   : advance one phase on this edge
//   dir    : 1 = forward (up), 0 = reverse (down)
//   phase  : current quadrature phase {B,A}
module quadstep
  import quadgen_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       step,
  input  logic       dir,
  output logic [1:0] phase
);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (reset) begin
      phase <= PH_0;
    end else if (step) begin
      phase <= phase_next(phase, dir);
    end
  end

endmodule

// File: rtl/quadgen.sv
// Quadrature step generator. A load command starts a move of 'steps' phase
// transitions in direction 'dir'; each step is taken after DWELL ce ticks.
//   clk       : rising-edge clock
//   reset     : synchronous active-high reset
//   ce        : rate enable for the dwell counter
//   load      : start strobe, accepted only while idle
//   steps     : step count for the move (0 gives an immediate done)
//   dir       : 1 = up / forward, 0 = down / reverse
//   abort     : terminate an active move without a done pulse
//   invphase  : swap tach bits at the output (live)
//   tach      : quadrature output {B,A}
//   busy      : move in progress
//   done      : one-cycle pulse at normal completion
//   stepsleft : steps remaining in the current move
//   position  : signed running position, wraps modulo 2^16
module quadgen
  import quadgen_pkg::*;
#(
  parameter int DWELL = DWELL_DEFAULT
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ce,
  input  logic                     load,
  input  logic [STEP_W-1:0]        steps,
  input  logic                     dir,
  input  logic                     abort,
  input  logic                     invphase,
  output logic [1:0]               tach,
  output logic                     busy,
  output logic                     done,
  output logic [STEP_W-1:0]        stepsleft,
  output logic signed [STEP_W-1:0] position
);

  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL - 1);

  state_t           state;
  logic [CNT_W-1:0] dwell_cnt;
  logic             dir_q;
  logic [1:0]       phase;
  logic             step_now;

  // A step is due on the ce tick that completes the dwell; abort wins.
  assign step_now = (state == ST_RUN) && ce && !abort && (dwell_cnt == DWELL_LAST);

  quadstep u_quadstep (
    .clk   (clk),
    .reset (reset),
    .step  (step_now),
    .dir   (dir_q),
    .phase (phase)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      dwell_cnt <= '0;
      stepsleft <= '0;
      dir_q     <= 1'b0;
      done      <= 1'b0;
      position  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (load && !abort) begin
            if (steps != '0) begin
              state     <= ST_RUN;
              stepsleft <= steps;
              dir_q     <= dir;
              dwell_cnt <= '0;
            end else begin
              done <= 1'b1;  // empty move completes at once
            end
          end
        end
        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            stepsleft <= '0;
            dwell_cnt <= '0;
          end else if (ce) begin
            if (dwell_cnt == DWELL_LAST) begin
              dwell_cnt <= '0;
              stepsleft <= stepsleft - 1'b1;
              position  <= dir_q ? position + 16'sd1 : position - 16'sd1;
              if (stepsleft == 16'd1) begin
                state <= ST_IDLE;
                done  <= 1'b1;
              end
            end else begin
              dwell_cnt <= dwell_cnt + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign busy = (state == ST_RUN);

  // NOTE: combinational blocks assign every output on every path (here a
  // default first) so no latch is inferred.
  always_comb begin
    tach = phase;
    if (invphase) tach = {phase[0], phase[1]};
  end

endmodule

// File: tb/tb_quadgen.sv
module tb_quadgen;

  logic        clk = 1'b0;
  logic        reset, ce, load, dir, abort, invphase;
  logic [15:0] steps;

  logic [1:0]        tach1, tach2;
  logic              busy1, busy2, done1, done2;
  logic [15:0]       left1, left2;
  logic signed [15:0] pos1, pos2;

  // sel chooses which instance the scenario checks: 0 = DWELL 4, 1 = DWELL 2
  bit sel = 1'b0;
  wire [1:0]  o_tach = sel ? tach2 : tach1;
  wire        o_busy = sel ? busy2 : busy1;
  wire        o_done = sel ? done2 : done1;
  wire [15:0] o_left = sel ? left2 : left1;
  wire [15:0] o_pos  = sel ? pos2  : pos1;

  int n_checks = 0;
  int n_fail   = 0;
  logic [15:0] model_pos = '0;

  // Loopback quadrature counter state
  bit          dec_en = 1'b0;
  int          dec_prev;
  logic [15:0] dec_cnt;
  int          dec_err = 0;

  quadgen #(.DWELL(4)) dut1 (
    .clk(clk), .reset(reset), .ce(ce), .load(load), .steps(steps), .dir(dir),
    .abort(abort), .invphase(invphase), .tach(tach1), .busy(busy1),
    .done(done1), .stepsleft(left1), .position(pos1)
  );

  quadgen #(.DWELL(2)) dut2 (
    .clk(clk), .reset(reset), .ce(ce), .load(load), .steps(steps), .dir(dir),
    .abort(abort), .invphase(invphase), .tach(tach2), .busy(busy2),
    .done(done2), .stepsleft(left2), .position(pos2)
  );

  always #5 clk = ~clk;

  // Phase k of the forward sequence 00,01,11,10
  function automatic logic [1:0] gray(input logic [1:0] k);
    case (k)
      2'd0:    return 2'b00;
      2'd1:    return 2'b01;
      2'd2:    return 2'b11;
      default: return 2'b10;
    endcase
  endfunction

  function automatic int gray_idx(input logic [1:0] g);
    case (g)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [1:0] exp_tach_of(input logic [15:0] p, input logic inv);
    logic [1:0] ph;
    ph = gray(p[1:0]);
    return inv ? {ph[0], ph[1]} : ph;
  endfunction

  // Independent quadrature counter fed from dut1's tach, undoing invphase.
  always @(negedge clk) begin
    if (dec_en) begin
      int idx, d;
      idx = gray_idx(invphase ? {tach1[0], tach1[1]} : tach1);
      d = (idx - dec_prev) & 3;
      if (d == 1) dec_cnt = dec_cnt + 16'd1;
      else if (d == 3) dec_cnt = dec_cnt - 16'd1;
      else if (d == 2) dec_err++;
      dec_prev = idx;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load = 1'b0; abort = 1'b0; ce = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_pos = '0;
  endtask

  // Issue one load and follow the move to its end, checking every cycle
  // against a model: steps taken = (ce ticks while running) / DWELL.
  // ce_mode: 0 = always, N>0 = every Nth cycle, <0 = random.
  task automatic move(input int nsteps, input bit up, input int ce_mode,
                      input bit noise, input bit rand_inv, input string tag);
    int dwell, ce_cnt, sdone, prev;
    bit finished, exp_busy, exp_done;
    logic [15:0] start, exp_pos, exp_left;
    logic [1:0]  exp_tach;
    dwell    = sel ? 2 : 4;
    start    = model_pos;
    ce_cnt   = 0;
    prev     = 0;
    finished = 1'b0;
    exp_pos  = start;
    steps = 16'(nsteps); dir = up; load = 1'b1; abort = 1'b0; ce = 1'b1;
    tick();
    load = 1'b0;
    for (int c = 0; c < 6000 && !finished; c++) begin
      sdone = ce_cnt / dwell;
      if (sdone > nsteps) sdone = nsteps;
      exp_busy = (sdone < nsteps);
      exp_done = (nsteps == 0) ? (c == 0) : ((sdone == nsteps) && (prev < nsteps));
      exp_pos  = up ? start + 16'(sdone) : start - 16'(sdone);
      exp_left = 16'(nsteps - sdone);
      exp_tach = exp_tach_of(exp_pos, invphase);
      n_checks += 5;
      if (o_tach !== exp_tach) begin
        n_fail++; $display("FAIL %s tach c=%0d: got %b want %b", tag, c, o_tach, exp_tach);
      end
      if (o_busy !== exp_busy) begin
        n_fail++; $display("FAIL %s busy c=%0d: got %b want %b", tag, c, o_busy, exp_busy);
      end
      if (o_done !== exp_done) begin
        n_fail++; $display("FAIL %s done c=%0d: got %b want %b", tag, c, o_done, exp_done);
      end
      if (o_left !== exp_left) begin
        n_fail++; $display("FAIL %s stepsleft c=%0d: got %0d want %0d", tag, c, o_left, exp_left);
      end
      if (o_pos !== exp_pos) begin
        n_fail++; $display("FAIL %s position c=%0d: got %h want %h", tag, c, o_pos, exp_pos);
      end
      prev = sdone;
      if (!exp_busy && !exp_done) finished = 1'b1;
      if (!finished) begin
        if (ce_mode == 0) ce = 1'b1;
        else if (ce_mode > 0) ce = ((c % ce_mode) == ce_mode - 1);
        else ce = 1'($urandom_range(0, 1));
        if (rand_inv) invphase = 1'($urandom_range(0, 1));
        if (noise && exp_busy) begin
          load  = ($urandom_range(0, 2) == 0);
          steps = 16'($urandom);
          dir   = 1'($urandom);
        end
        tick();
        if (exp_busy && ce) ce_cnt++;
        load = 1'b0;
      end
    end
    n_checks++;
    if (!finished) begin
      n_fail++; $display("FAIL %s timeout: got busy=%b want idle", tag, o_busy);
    end
    model_pos = exp_pos;
  endtask

  task automatic test_reset();
    reset = 1'b1; load = 1'b1; steps = 16'd7; dir = 1'b1; ce = 1'b1; abort = 1'b0;
    for (int i = 0; i < 2; i++) begin
      invphase = 1'(i);
      tick();
      n_checks += 5;
      if (o_tach !== 2'b00) begin n_fail++; $display("FAIL reset tach: got %b want 00", o_tach); end
      if (o_busy !== 1'b0) begin n_fail++; $display("FAIL reset busy: got %b want 0", o_busy); end
      if (o_done !== 1'b0) begin n_fail++; $display("FAIL reset done: got %b want 0", o_done); end
      if (o_left !== 16'd0) begin n_fail++; $display("FAIL reset stepsleft: got %0d want 0", o_left); end
      if (o_pos !== 16'd0) begin n_fail++; $display("FAIL reset position: got %h want 0000", o_pos); end
    end
    load = 1'b0; reset = 1'b0; invphase = 1'b0;
    model_pos = '0;
  endtask

  task automatic test_basic_up();
    do_reset();
    invphase = 1'b0;
    move(3, 1'b1, 0, 1'b0, 1'b0, "up3");
  endtask

  task automatic test_down_from_10();
    // position 3 leaves phase 10; this also drives ignored loads while busy
    move(5, 1'b0, 0, 1'b1, 1'b0, "down5");
  endtask

  task automatic test_ce_rate();
    do_reset();
    sel = 1'b1;
    move(2, 1'b1, 3, 1'b0, 1'b1, "ce3");
    sel = 1'b0;
  endtask

  task automatic test_wrap();
    do_reset();
    move(1, 1'b0, 0, 1'b0, 1'b0, "wrapdn");
    n_checks++;
    if (o_pos !== 16'hFFFF) begin n_fail++; $display("FAIL wrap down: got %h want FFFF", o_pos); end
    move(1, 1'b1, 0, 1'b0, 1'b0, "wrapup");
    n_checks++;
    if (o_pos !== 16'h0000) begin n_fail++; $display("FAIL wrap up: got %h want 0000", o_pos); end
  endtask

  task automatic test_abort();
    do_reset();
    invphase = 1'b0;
    steps = 16'd10; dir = 1'b1; load = 1'b1; ce = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 11; i++) tick();
    n_checks += 2;
    if (o_pos !== 16'd2) begin n_fail++; $display("FAIL abort pre position: got %0d want 2", o_pos); end
    if (o_left !== 16'd8) begin n_fail++; $display("FAIL abort pre stepsleft: got %0d want 8", o_left); end
    // abort lands on the edge where the third step is due
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks += 5;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b want 0", o_busy); end
    if (o_left !== 16'd0) begin n_fail++; $display("FAIL abort stepsleft: got %0d want 0", o_left); end
    if (o_pos !== 16'd2) begin n_fail++; $display("FAIL abort position: got %0d want 2", o_pos); end
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL abort done: got %b want 0", o_done); end
    if (o_tach !== 2'b11) begin n_fail++; $display("FAIL abort tach: got %b want 11", o_tach); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks += 2;
      if (o_done !== 1'b0) begin n_fail++; $display("FAIL abort late done: got %b want 0", o_done); end
      if (o_pos !== 16'd2) begin n_fail++; $display("FAIL abort hold position: got %0d want 2", o_pos); end
    end
    model_pos = 16'd2;
    move(0, 1'b1, 0, 1'b0, 1'b0, "zero");
    // abort and load together while idle: load must be ignored
    steps = 16'd5; load = 1'b1; abort = 1'b1;
    tick();
    load = 1'b0; abort = 1'b0;
    n_checks += 3;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL ldabort busy: got %b want 0", o_busy); end
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL ldabort done: got %b want 0", o_done); end
    if (o_left !== 16'd0) begin n_fail++; $display("FAIL ldabort stepsleft: got %0d want 0", o_left); end
  endtask

  task automatic test_reset_mid_move();
    steps = 16'd5; dir = 1'b1; load = 1'b1; ce = 1'b1; invphase = 1'b1;
    tick();
    load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    reset = 1'b1;
    tick();
    n_checks += 5;
    if (o_busy !== 1'b0) begin n_fail++; $display("FAIL rstmid busy: got %b want 0", o_busy); end
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL rstmid done: got %b want 0", o_done); end
    if (o_pos !== 16'd0) begin n_fail++; $display("FAIL rstmid position: got %h want 0000", o_pos); end
    if (o_left !== 16'd0) begin n_fail++; $display("FAIL rstmid stepsleft: got %0d want 0", o_left); end
    if (o_tach !== 2'b00) begin n_fail++; $display("FAIL rstmid tach: got %b want 00", o_tach); end
    reset = 1'b0;
    tick();
    n_checks++;
    if (o_done !== 1'b0) begin n_fail++; $display("FAIL rstmid late done: got %b want 0", o_done); end
    model_pos = '0;
    invphase = 1'b0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 15; i++)
      move($urandom_range(0, 12), 1'($urandom_range(0, 1)), -1, 1'b1, 1'b1, "rand");
  endtask

  task automatic test_loopback();
    int total, n;
    invphase = 1'b1;
    tick();
    dec_prev = gray_idx({tach1[0], tach1[1]});
    dec_cnt  = pos1;
    dec_err  = 0;
    dec_en   = 1'b1;
    total    = 0;
    while (total < 1000) begin
      n = $urandom_range(1, 25);
      if (n > 1000 - total) n = 1000 - total;
      move(n, 1'($urandom_range(0, 1)), 0, 1'b0, 1'b0, "loop");
      total += n;
      n_checks++;
      if (dec_cnt !== o_pos) begin
        n_fail++; $display("FAIL loopback count: got %h want %h", dec_cnt, o_pos);
      end
    end
    dec_en = 1'b0;
    n_checks++;
    if (dec_err !== 0) begin n_fail++; $display("FAIL loopback illegal jumps: got %0d want 0", dec_err); end
  endtask

  initial begin
    reset = 1'b1; ce = 1'b0; load = 1'b0; dir = 1'b0; abort = 1'b0;
    invphase = 1'b0; steps = '0;
    test_reset();
    test_basic_up();
    test_down_from_10();
    test_ce_rate();
    test_wrap();
    test_abort();
    test_reset_mid_move();
    test_back_to_back();
    test_loopback();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quadgen.md
QUADGEN -- requirements
Module: quadgen

Interface
REQ-001 Parameter DWELL, default 4: ce ticks spent in each quadrature state before advancing; legal range 1..255.
REQ-002 clk  input  1  rising-edge clock; sole clock.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 ce  input  1  rate enable; dwell counter advances only on cycles with ce=1.
REQ-005 load  input  1  single-cycle command strobe; accepted only when busy=0.
REQ-006 steps  input  16  unsigned step count, sampled with load.
REQ-007 dir  input  1  1=count up (forward), 0=count down; sampled with load.
REQ-008 abort  input  1  terminates an active move.
REQ-009 invphase  input  1  swaps tach[0]/tach[1] at output; live, not latched.
REQ-010 tach  output  2  registered quadrature output {B,A}.
REQ-011 busy  output  1  high while a move is in progress.
REQ-012 done  output  1  one-cycle pulse at normal move completion.
REQ-013 stepsleft  output  16  steps remaining in current move.
REQ-014 position  output  16  signed running position, two's complement.

Function
REQ-015 States IDLE and RUN; busy=1 exactly in RUN.
REQ-016 Internal phase sequence for up: 00->01->11->10->00; down is the reverse; one step = one phase transition.
REQ-017 tach = phase when invphase=0, {phase[0],phase[1]} when invphase=1; invphase change never alters phase or position.
REQ-018 IDLE, load=1, abort=0, steps>0: next edge -> RUN, stepsleft=steps, dir latched, dwell counter=0.
REQ-019 IDLE, load=1, steps=0: stay IDLE, done=1 on next cycle, no tach change.
REQ-020 load while busy=1: ignored, no effect on latched steps/dir.
REQ-021 RUN: each ce=1 cycle increments dwell counter; on the ce cycle where counter=DWELL-1, next edge advances phase one step, counter clears, stepsleft decrements, position +1 (up) or -1 (down).
REQ-022 First step occurs on the DWELL-th ce after load acceptance; each subsequent step exactly DWELL ce ticks later.
REQ-023 Final step (stepsleft 1->0): same edge sets busy=0, done=1 for one cycle, state IDLE.
REQ-024 position wraps modulo 2^16 (7FFF+1=8000, 0000-1=FFFF), no saturation.
REQ-025 abort=1 in RUN: next edge -> IDLE, stepsleft=0, dwell counter=0, phase and position hold, done stays 0; abort has priority over a step due same cycle.
REQ-026 abort and load same cycle in IDLE: load ignored.
REQ-027 Phase and position persist across moves; a new move continues from the current phase.
REQ-028 Output tach connected through an ideal channel to the team's quadrature counter yields one count per step in the commanded direction.

Reset
REQ-029 reset=1 at a clock edge: state IDLE, phase=00, tach=00 (either invphase), position=0, stepsleft=0, dwell counter=0, busy=0, done=0; overrides load, abort, ce.
REQ-030 reset mid-move discards the move with no done pulse.

Structure
REQ-031 Shared package holds state encoding (IDLE/RUN), the phase-sequence constants, and DWELL default.
REQ-032 One sub-module natural: quadstep, a 2-bit gray-phase register with step/dir inputs; dwell counter, step counter and FSM live in quadgen.

Verification
REQ-033 reset, DWELL=4, ce=1 always, load steps=3 dir=1 -> tach 01,11,10 at cycles 4,8,12 after load; position=3; done once, on cycle 12.
REQ-034 From phase 10, load steps=5 dir=0 -> tach 11,01,00,10,11; position decrements by 5; stepsleft 5..0.
REQ-035 ce asserted every 3rd cycle, DWELL=2, steps=2 -> steps spaced 6 clk cycles; busy high throughout, low with done.
REQ-036 position=0, load steps=1 dir=0 -> position=FFFF; then steps=1 dir=1 -> 0000.
REQ-037 abort after 2 of 10 steps -> busy=0 next edge, stepsleft=0, position=2, no done; load during busy ignored; steps=0 load -> done only.
REQ-038 Loopback to the quadrature counter with invphase=1 on both -> counter tracks position for 1000 random-direction steps.
